// File: rtl/adc_reset_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_ctrl_pkg: sequencer state encoding, reset command, timing    |
// | defaults shared with the timing hub.            rev 1.0          |
// +------------------------------------------------------------------+
package adc_ctrl_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_CS_SETUP  = 3'd1;
  localparam seq_state_t ST_SHIFT     = 3'd2;
  localparam seq_state_t ST_CS_HOLD   = 3'd3;
  localparam seq_state_t ST_SYNC_LOW  = 3'd4;
  localparam seq_state_t ST_POST_WAIT = 3'd5;
  localparam seq_state_t ST_DONE      = 3'd6;

  localparam logic [31:0] ADC_RESET_CMD = 32'h0000_0011;

  // Quiet time after reset spans eight timestamp periods of the hub.
  localparam int TS_TICKS       = 64;
  localparam int POST_TICKS_DEF = 8 * TS_TICKS;

  localparam int SCLK_HALF_DEF  = 4;
  localparam int CMD_BITS_DEF   = 16;
  localparam int CS_SETUP_DEF   = 2;
  localparam int CS_HOLD_DEF    = 2;
  localparam int SYNC_LOW_DEF   = 16;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that is loaded with max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_reset_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_reset_sequencer_if: request/status handshake and ADC pins.   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface adc_reset_sequencer_if;
  logic       adc_sync_req;
  logic       busy;
  logic       done;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       adc_sync_n;
  logic [7:0] req_coalesced;

  modport master (
    output adc_sync_req,
    input  busy, done, spi_cs_n, spi_sclk, spi_mosi, adc_sync_n, req_coalesced
  );

  modport slave (
    input  adc_sync_req,
    output busy, done, spi_cs_n, spi_sclk, spi_mosi, adc_sync_n, req_coalesced
  );
endinterface
`default_nettype wire

// File: rtl/adc_reset_sequencer_spi_cmd_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_cmd_shifter: CS-framed, CPHA=1 transmit of one command word. |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module spi_cmd_shifter
  import adc_ctrl_pkg::*;
#(
  parameter int          SCLK_HALF      = SCLK_HALF_DEF,
  parameter int          CMD_BITS       = CMD_BITS_DEF,
  parameter logic [31:0] CMD_WORD       = ADC_RESET_CMD,
  parameter int          CS_SETUP_TICKS = CS_SETUP_DEF,
  parameter int          CS_HOLD_TICKS  = CS_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic setup_end,
  output logic shift_end,
  output logic done,
  output logic cs_n,
  output logic sclk,
  output logic mosi
);

  localparam int TW = cnt_width(imax(SCLK_HALF, imax(CS_SETUP_TICKS, CS_HOLD_TICKS)));
  localparam int BW = cnt_width(CMD_BITS);

  localparam logic [TW-1:0]       c_setup_load = TW'(CS_SETUP_TICKS - 1);
  localparam logic [TW-1:0]       c_half_load  = TW'(SCLK_HALF - 1);
  localparam logic [TW-1:0]       c_hold_load  = TW'(CS_HOLD_TICKS - 1);
  localparam logic [BW-1:0]       c_bit_load   = BW'(CMD_BITS - 1);
  localparam logic [CMD_BITS-1:0] c_cmd        = CMD_WORD[CMD_BITS-1:0];

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_SHIFT = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  logic [1:0]          r_phase;
  logic [TW-1:0]       r_tick;
  logic [BW-1:0]       r_bit;
  logic [CMD_BITS-1:0] r_shreg;
  logic                r_cs_n;
  logic                r_sclk;
  logic                r_mosi;
  logic                w_tick_zero;

  assign w_tick_zero = (r_tick == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          // MSB goes out with CS so it is stable through the setup time.
          if (start) begin
            r_phase <= PH_SETUP;
            r_tick  <= c_setup_load;
            r_bit   <= c_bit_load;
            r_shreg <= c_cmd << 1;
            r_cs_n  <= 1'b0;
            r_mosi  <= c_cmd[CMD_BITS-1];
          end
        end
        PH_SETUP: begin
          if (w_tick_zero) begin
            r_phase <= PH_SHIFT;
            r_sclk  <= 1'b1;
            r_tick  <= c_half_load;
          end else begin
            r_tick <= r_tick - 1'b1;
          end
        end
        PH_SHIFT: begin
          if (!w_tick_zero) begin
            r_tick <= r_tick - 1'b1;
          end else if (r_sclk) begin
            r_sclk <= 1'b0;
            r_tick <= c_half_load;
          end else if (r_bit == '0) begin
            r_phase <= PH_HOLD;
            r_mosi  <= 1'b0;
            r_tick  <= c_hold_load;
          end else begin
            // Next bit changes together with the rising edge.
            r_bit   <= r_bit - 1'b1;
            r_sclk  <= 1'b1;
            r_mosi  <= r_shreg[CMD_BITS-1];
            r_shreg <= r_shreg << 1;
            r_tick  <= c_half_load;
          end
        end
        PH_HOLD: begin
          if (w_tick_zero) begin
            r_phase <= PH_IDLE;
            r_cs_n  <= 1'b1;
          end else begin
            r_tick <= r_tick - 1'b1;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign setup_end = (r_phase == PH_SETUP) && w_tick_zero;
  assign shift_end = (r_phase == PH_SHIFT) && w_tick_zero && !r_sclk && (r_bit == '0);
  assign done      = (r_phase == PH_HOLD) && w_tick_zero;
  assign cs_n      = r_cs_n;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;

endmodule
`default_nettype wire

// File: rtl/adc_reset_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_reset_sequencer: SPI reset command, optional SYNC pulse      |
// | (ADC_SYNC_PIN_EN), quiet time, done.             rev 1.0         |
// +------------------------------------------------------------------+
module adc_reset_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int          SCLK_HALF      = SCLK_HALF_DEF,
  parameter int          CMD_BITS       = CMD_BITS_DEF,
  parameter logic [31:0] CMD_WORD       = ADC_RESET_CMD,
  parameter int          CS_SETUP_TICKS = CS_SETUP_DEF,
  parameter int          CS_HOLD_TICKS  = CS_HOLD_DEF,
  parameter int          SYNC_LOW_TICKS = SYNC_LOW_DEF,
  parameter int          POST_TICKS     = POST_TICKS_DEF
) (
  input  logic                  clk_ctrl,
  input  logic                  rst_ctrl,
  adc_reset_sequencer_if.slave  bus
);

  localparam int CW = cnt_width(imax(SYNC_LOW_TICKS, POST_TICKS));

  localparam logic [CW-1:0] c_post_load = CW'(POST_TICKS - 1);
`ifdef ADC_SYNC_PIN_EN
  localparam logic [CW-1:0] c_sync_load  = CW'(SYNC_LOW_TICKS - 1);
  localparam seq_state_t    c_after_hold = ST_SYNC_LOW;
  localparam logic [CW-1:0] c_hold_load  = c_sync_load;
`else
  localparam seq_state_t    c_after_hold = ST_POST_WAIT;
  localparam logic [CW-1:0] c_hold_load  = c_post_load;
`endif

  seq_state_t r_state;
  seq_state_t w_next;
  logic [CW-1:0] r_wait;
  logic          r_pending;
  logic [7:0]    r_coalesced;
  logic          w_start;
  logic          w_req_busy;
  logic          w_wait_zero;
  logic          w_sh_setup_end;
  logic          w_sh_shift_end;
  logic          w_sh_done;
  logic          w_busy;
  logic          w_done;
  logic          w_sync_n;

  assign w_start = ((r_state == ST_IDLE) && (bus.adc_sync_req || r_pending)) ||
                   ((r_state == ST_DONE) && r_pending);
  assign w_req_busy  = bus.adc_sync_req && (r_state != ST_IDLE);
  assign w_wait_zero = (r_wait == '0);

  spi_cmd_shifter #(
    .SCLK_HALF      (SCLK_HALF),
    .CMD_BITS       (CMD_BITS),
    .CMD_WORD       (CMD_WORD),
    .CS_SETUP_TICKS (CS_SETUP_TICKS),
    .CS_HOLD_TICKS  (CS_HOLD_TICKS)
  ) u_shifter (
    .clk       (clk_ctrl),
    .rst       (rst_ctrl),
    .start     (w_start),
    .setup_end (w_sh_setup_end),
    .shift_end (w_sh_shift_end),
    .done      (w_sh_done),
    .cs_n      (bus.spi_cs_n),
    .sclk      (bus.spi_sclk),
    .mosi      (bus.spi_mosi)
  );

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_start)        w_next = ST_CS_SETUP;
      ST_CS_SETUP:  if (w_sh_setup_end) w_next = ST_SHIFT;
      ST_SHIFT:     if (w_sh_shift_end) w_next = ST_CS_HOLD;
      ST_CS_HOLD:   if (w_sh_done)      w_next = c_after_hold;
      ST_SYNC_LOW:  if (w_wait_zero)    w_next = ST_POST_WAIT;
      ST_POST_WAIT: if (w_wait_zero)    w_next = ST_DONE;
      ST_DONE:      w_next = r_pending ? ST_CS_SETUP : ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_sync_n = 1'b1;
    case (r_state)
      ST_IDLE: ;
      ST_DONE: w_done = 1'b1;
`ifdef ADC_SYNC_PIN_EN
      ST_SYNC_LOW: begin
        w_busy   = 1'b1;
        w_sync_n = 1'b0;
      end
`endif
      default: w_busy = 1'b1;
    endcase
  end

  // Shared down-counter for the SYNC low width and the post-reset quiet time.
  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      r_wait <= '0;
    end else if ((r_state == ST_CS_HOLD) && w_sh_done) begin
      r_wait <= c_hold_load;
    end else if ((r_state == ST_SYNC_LOW) && w_wait_zero) begin
      r_wait <= c_post_load;
    end else if (((r_state == ST_SYNC_LOW) || (r_state == ST_POST_WAIT)) && !w_wait_zero) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      r_pending   <= 1'b0;
      r_coalesced <= 8'h00;
    end else if (w_req_busy) begin
      r_pending <= 1'b1;
      if (r_coalesced != 8'hFF) begin
        r_coalesced <= r_coalesced + 8'd1;
      end
    end else if (w_start) begin
      r_pending <= 1'b0;
    end
  end

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.adc_sync_n    = w_sync_n;
  assign bus.req_coalesced = r_coalesced;

endmodule
`default_nettype wire

// File: tb/tb_adc_reset_sequencer.sv
`default_nettype none
// Directed bench for adc_reset_sequencer: default instance plus a
// one-bit / one-tick corner instance on the same clock and reset.
module tb_adc_reset_sequencer;

`ifdef ADC_SYNC_PIN_EN
  localparam int SYNC_T = 16;
`else
  localparam int SYNC_T = 0;
`endif
  localparam int   TOT  = 1 + 2 + 128 + 2 + SYNC_T + 512;
  localparam int   TOT1 = 1 + 2 + 2 + 2 + SYNC_T + 512;
  localparam logic SYL  = (SYNC_T == 0);

  logic clk_ctrl = 1'b0;
  logic rst_ctrl = 1'b1;
  always #5 clk_ctrl = ~clk_ctrl;

  adc_reset_sequencer_if bus ();
  adc_reset_sequencer_if bus1 ();

  adc_reset_sequencer dut (
    .clk_ctrl (clk_ctrl),
    .rst_ctrl (rst_ctrl),
    .bus      (bus)
  );

  adc_reset_sequencer #(
    .SCLK_HALF (1),
    .CMD_BITS  (1),
    .CMD_WORD  (32'h1)
  ) dut1 (
    .clk_ctrl (clk_ctrl),
    .rst_ctrl (rst_ctrl),
    .bus      (bus1)
  );

  // pins = {busy, done, cs_n, sclk, mosi, sync_n}
  typedef struct {
    int         cyc;
    logic [5:0] pins;
  } vec_t;
  vec_t vecs[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int base     = 0;
  int busy_lo  = 0;
  int rises[2], werr[2], ndone[2], done_at[2], sync_lo[2], last_rise[2], hi_len[2];
  logic [31:0] cap[2];
  logic        prev_sclk[2];

  function automatic logic [5:0] pins0();
    return {bus.busy, bus.done, bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.adc_sync_n};
  endfunction

  function automatic logic [5:0] pins1();
    return {bus1.busy, bus1.done, bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_mosi, bus1.adc_sync_n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s (rel cycle %0d): got 0x%0h, expected 0x%0h", name, cyc - base, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [5:0] p);
    vec_t v;
    v.cyc  = c;
    v.pins = p;
    vecs.push_back(v);
  endtask

  task automatic mon_clear();
    for (int k = 0; k < 2; k++) begin
      rises[k] = 0; werr[k] = 0; ndone[k] = 0; done_at[k] = -1;
      sync_lo[k] = 0; last_rise[k] = -1; hi_len[k] = 0;
      cap[k] = '0; prev_sclk[k] = 1'b0;
    end
  endtask

  task automatic mon_one(input int k, input int half, input logic [5:0] p);
    int rel;
    rel = cyc - base;
    if (p[3]) last_rise[k] = -1;
    if (p[2] && !prev_sclk[k]) begin
      rises[k]++;
      if (last_rise[k] >= 0 && (rel - last_rise[k]) != 2 * half) werr[k]++;
      last_rise[k] = rel;
      hi_len[k] = 0;
    end
    if (p[2]) hi_len[k]++;
    if (!p[2] && prev_sclk[k]) begin
      if (hi_len[k] != half) werr[k]++;
      cap[k] = {cap[k][30:0], p[1]};
    end
    if (!p[0]) sync_lo[k]++;
    if (p[4]) begin
      ndone[k]++;
      done_at[k] = rel;
    end
    prev_sclk[k] = p[2];
  endtask

  task automatic step();
    @(posedge clk_ctrl);
    #1;
    cyc++;
    mon_one(0, 4, pins0());
    mon_one(1, 1, pins1());
  endtask

  initial begin
    bus.adc_sync_req  = 1'b0;
    bus1.adc_sync_req = 1'b0;
    rst_ctrl = 1'b1;
    mon_clear();

    add(0,       6'b001001);
    add(10,      6'b001001);
    add(11,      6'b100001);
    add(12,      6'b100001);
    add(13,      6'b100101);
    add(16,      6'b100101);
    add(17,      6'b100001);
    add(101,     6'b100111);
    add(108,     6'b100011);
    add(109,     6'b100101);
    add(133,     6'b100111);
    add(140,     6'b100011);
    add(141,     6'b100001);
    add(142,     6'b100001);
    add(143,     {5'b10100, SYL});
    add(158,     {5'b10100, SYL});
    add(159,     6'b101001);
    add(TOT + 9,  6'b101001);
    add(TOT + 10, 6'b011001);
    add(TOT + 11, 6'b001001);

    repeat (3) step();
    check("reset_coalesced", bus.req_coalesced, 32'h0);

    // Basic sequence, request at cycle 10 on both instances.
    rst_ctrl = 1'b0;
    base = cyc;
    mon_clear();
    for (int c = 0; c <= TOT + 30; c++) begin
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) check($sformatf("vec_c%0d", c), pins0(), vecs[i].pins);
      end
      bus.adc_sync_req  = (c == 10);
      bus1.adc_sync_req = (c == 10);
      step();
    end
    check("basic_sclk_pulses", rises[0], 16);
    check("basic_sclk_timing", werr[0], 0);
    check("basic_mosi_word",   cap[0], 32'h0011);
    check("basic_sync_low",    sync_lo[0], SYNC_T);
    check("basic_done_cycle",  done_at[0], TOT + 10);
    check("basic_done_count",  ndone[0], 1);
    check("corner_pulses",     rises[1], 1);
    check("corner_timing",     werr[1], 0);
    check("corner_mosi",       cap[1], 32'h1);
    check("corner_sync_low",   sync_lo[1], SYNC_T);
    check("corner_done_cycle", done_at[1], TOT1 + 10);
    check("corner_done_count", ndone[1], 1);

    // Coalescing: two extra requests merge into a single rerun.
    base = cyc;
    mon_clear();
    busy_lo = 0;
    for (int c = 0; c < 2 * TOT + 20; c++) begin
      if (c >= 1 && c < 2 * TOT && !bus.busy) busy_lo++;
      if (c == 50)      check("coal_count", bus.req_coalesced, 32'd2);
      if (c == TOT)     check("coal_done_cycle", {bus.busy, bus.done}, 32'b01);
      if (c == TOT + 1) check("coal_rerun_start", {bus.busy, bus.spi_cs_n}, 32'b10);
      bus.adc_sync_req = (c == 0 || c == 5 || c == 40);
      step();
    end
    check("coal_busy_gap",   busy_lo, 1);
    check("coal_done_count", ndone[0], 2);
    check("coal_rerun_done", done_at[0], 2 * TOT);
    check("coal_words",      cap[0], 32'h0011_0011);

    // Reset at the end of bit 7, coincident with a request.
    base = cyc;
    mon_clear();
    for (int c = 0; c <= 74; c++) begin
      bus.adc_sync_req = (c == 0 || c == 74);
      rst_ctrl = (c == 74);
      step();
    end
    rst_ctrl = 1'b0;
    bus.adc_sync_req = 1'b0;
    check("rst_pins",         pins0(), 32'b001001);
    check("rst_partial_bits", rises[0], 9);
    check("rst_coalesced",    bus.req_coalesced, 32'h0);
    mon_clear();
    busy_lo = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy || !bus.spi_cs_n) busy_lo++;
      step();
    end
    check("rst_idle_after", busy_lo, 0);
    check("rst_no_done",    ndone[0], 0);
    check("rst_no_resume",  rises[0], 0);

    base = cyc;
    mon_clear();
    for (int c = 0; c < TOT + 10; c++) begin
      bus.adc_sync_req = (c == 0);
      step();
    end
    check("fresh_word",       cap[0], 32'h0011);
    check("fresh_pulses",     rises[0], 16);
    check("fresh_done_cycle", done_at[0], TOT);

    // Saturation: 300 requests inside one busy window.
    base = cyc;
    mon_clear();
    for (int c = 0; c < 2 * TOT + 20; c++) begin
      if (c == 201) check("sat_partial", bus.req_coalesced, 32'd100);
      if (c == 620) check("sat_count",   bus.req_coalesced, 32'hFF);
      bus.adc_sync_req = (c == 0) || (c >= 2 && c <= 600 && (c % 2) == 0);
      step();
    end
    check("sat_done_count", ndone[0], 2);
    check("sat_rerun_done", done_at[0], 2 * TOT);
    check("sat_hold",       bus.req_coalesced, 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
